// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on device clock, ack check.
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to two times before flagging tx_error.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 2400,
    parameter int REQ_CYC     = 240,
    parameter int TIMEOUT_CYC = 360000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_tx_done,
    output logic       o_tx_error
);
    localparam int TMAX_IR = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int TMAX    = (TIMEOUT_CYC > TMAX_IR) ? TIMEOUT_CYC : TMAX_IR;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_byte;
    logic            r_par;
    logic            r_clk_oe, r_dat_oe, r_done, r_err;
    logic            w_clk_oe_nxt, w_dat_oe_nxt, w_done_nxt, w_err_nxt;
    logic            w_tmr_clr, w_accept, w_fail, w_fe, w_tmo;

    // Index 0 is the clock pin, index 1 the data pin.
    logic [1:0]      r_s1, r_s2, r_flt;
    logic            r_clk_flt_d;
    logic [FW-1:0]   r_fcnt [2];

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_s1        <= 2'b11;
            r_s2        <= 2'b11;
            r_flt       <= 2'b11;
            r_clk_flt_d <= 1'b1;
            r_fcnt[0]   <= '0;
            r_fcnt[1]   <= '0;
        end else begin
            r_s1        <= {i_ps2_dat, i_ps2_clk};
            r_s2        <= r_s1;
            r_clk_flt_d <= r_flt[0];
            for (int k = 0; k < 2; k++) begin
                if (r_s2[k] == r_flt[k]) begin
                    r_fcnt[k] <= '0;
                end else if (r_fcnt[k] == FW'(FILTER_LEN - 1)) begin
                    r_flt[k]  <= r_s2[k];
                    r_fcnt[k] <= '0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + FW'(1);
                end
            end
        end
    end

    assign w_fe  = r_clk_flt_d & ~r_flt[0];
    assign w_tmo = (r_timer == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_TX_RETRY_EN
    logic [1:0] r_retry;
    logic       w_retry_inc;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_tmr_clr    = 1'b0;
        w_bit_nxt    = r_bit;
        w_accept     = 1'b0;
        w_fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry_inc  = 1'b0;
`endif
        case (r_state)
            S_IDLE: if (i_tx_valid) begin
                w_accept     = 1'b1;
                w_state_nxt  = S_INHIBIT;
                w_clk_oe_nxt = 1'b1;
                w_dat_oe_nxt = 1'b0;
                w_tmr_clr    = 1'b1;
            end
            S_INHIBIT: if (r_timer == TW'(INHIBIT_CYC - 1)) begin
                w_state_nxt  = S_REQ;
                w_dat_oe_nxt = 1'b1;
                w_tmr_clr    = 1'b1;
            end
            S_REQ: if (r_timer == TW'(REQ_CYC - 1)) begin
                w_state_nxt  = S_SEND;
                w_clk_oe_nxt = 1'b0;
                w_tmr_clr    = 1'b1;
                w_bit_nxt    = 4'd0;
            end
            S_SEND: begin
                if (w_fe) begin
                    w_tmr_clr = 1'b1;
                    w_bit_nxt = r_bit + 4'd1;
                    if (r_bit < 4'd8) begin
                        w_dat_oe_nxt = ~r_byte[r_bit[2:0]];
                    end else if (r_bit == 4'd8) begin
                        w_dat_oe_nxt = ~r_par;
                    end else begin
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = S_ACK;
                    end
                end else if (w_tmo) begin
                    w_fail = 1'b1;
                end
            end
            S_ACK: begin
                if (w_fe) begin
                    w_tmr_clr = 1'b1;
                    if (!r_flt[1]) w_state_nxt = S_WAIT_IDLE;
                    else           w_fail      = 1'b1;
                end else if (w_tmo) begin
                    w_fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_flt[0] && r_flt[1]) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_fail = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Lines are released in the same cycle a failure is seen.
        if (w_fail) begin
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_tmr_clr    = 1'b1;
`ifdef PS2_TX_RETRY_EN
            if (r_retry != 2'd2) begin
                w_retry_inc  = 1'b1;
                w_state_nxt  = S_INHIBIT;
                w_clk_oe_nxt = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 1'b1;
            end
`else
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
`endif
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_par    <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            if (w_tmr_clr)              r_timer <= '0;
            else if (r_state != S_IDLE) r_timer <= r_timer + TW'(1);
            r_bit    <= w_bit_nxt;
            r_clk_oe <= w_clk_oe_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            if (w_accept) begin
                r_byte <= i_tx_data;
                r_par  <= ~^i_tx_data;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge i_clk_sys) begin
        if (i_reset || w_accept) r_retry <= 2'd0;
        else if (w_retry_inc)    r_retry <= r_retry + 2'd1;
    end
`endif

    assign o_tx_ready   = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_ps2_clk_oe = r_clk_oe;
    assign o_ps2_dat_oe = r_dat_oe;
    assign o_tx_done    = r_done;
    assign o_tx_error   = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, frame table, random bytes, timeout/reset corners.
module tb_ps2_host_tx;
    localparam int INH = 40, REQ = 12, TMO = 400, FLT = 8, HALF = 25;
`ifdef PS2_TX_RETRY_EN
    localparam int RETRIES = 2;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, clk_oe, dat_oe, busy, done, err;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    logic       line_clk, line_dat;
    int         n_chk = 0, n_fail = 0, n_done = 0, n_err = 0;

    assign line_clk = ~(clk_oe | dev_clk_low);
    assign line_dat = ~(dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .REQ_CYC(REQ), .TIMEOUT_CYC(TMO), .FILTER_LEN(FLT)) dut (
        .i_clk_sys(clk), .i_reset(rst), .i_tx_data(data), .i_tx_valid(valid), .o_tx_ready(ready),
        .i_ps2_clk(line_clk), .i_ps2_dat(line_dat), .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe),
        .o_busy(busy), .o_tx_done(done), .o_tx_error(err));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (done) n_done++;
        if (err)  n_err++;
    end

    typedef struct {
        logic [7:0]  b;
        bit          ack;
        bit          glitch;
        logic [10:0] frame;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bit order seen by the device: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_req(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("ready_drop", ready, 0);
        chk("busy_set", busy, 1);
    endtask

    task automatic measure_req(input bit chk_inh);
        int c = 0;
        while (!clk_oe && c < 3000) begin c++; tick(); end
        if (!clk_oe) chk("inhibit_start_timeout", 0, 1);
        c = 0;
        while (clk_oe && !dat_oe && c < 5000) begin c++; tick(); end
        if (chk_inh) chk("inhibit_len", c, INH);
        c = 0;
        while (clk_oe && dat_oe && c < 5000) begin c++; tick(); end
        chk("req_len", c, REQ);
        chk("start_bit_low", line_dat, 0);
    endtask

    task automatic dev_frame(input int pulses, input bit ack, input bit glitch, output logic [10:0] smp);
        smp    = '0;
        smp[0] = line_dat;
        repeat (30) tick();
        for (int p = 1; p <= pulses; p++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (p == 11) begin
                repeat (5) tick();
                dev_dat_low = 1'b0;
                repeat (30) tick();
            end else begin
                tick();
                smp[p] = line_dat;
                if (p == 10) dev_dat_low = ack;
                for (int h = 1; h < HALF; h++) begin
                    dev_clk_low = glitch && (h >= 10) && (h < 13);
                    tick();
                end
                dev_clk_low = 1'b0;
            end
        end
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input bit glitch, input logic [10:0] exp_f);
        int d0 = n_done, e0 = n_err;
        int att = ack ? 1 : RETRIES + 1;
        logic [10:0] smp;
        start_req(b);
        for (int a = 0; a < att; a++) begin
            measure_req(a == 0);
            dev_frame(11, ack, glitch, smp);
            chk($sformatf("frame_%02h", b), smp, exp_f);
        end
        chk("idle_after", ready, 1);
        chk("done_cnt", n_done - d0, ack ? 1 : 0);
        chk("err_cnt", n_err - e0, ack ? 0 : 1);
        chk("oe_released", {clk_oe, dat_oe}, 0);
    endtask

    vec_t tbl[5];

    initial begin
        logic [10:0] smp;
        int          d0, e0, n;

        tbl[0] = '{8'hED, 1'b1, 1'b0, 11'b1_1_11101101_0};
        tbl[1] = '{8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0};
        tbl[3] = '{8'hA5, 1'b1, 1'b1, 11'b1_1_10100101_0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 11'b1_1_00111100_0};

        repeat (3) tick();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {clk_oe, dat_oe}, 0);
        chk("rst_pulses", {done, err}, 0);
        rst = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < 5; i++) begin
            run_xfer(tbl[i].b, tbl[i].ack, tbl[i].glitch, tbl[i].frame);
            repeat (10) tick();
        end

        for (int i = 0; i < 6; i++) begin
            logic [7:0] rb;
            bit         rack, rgl;
            rb   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            rgl  = $urandom_range(0, 1) == 1;
            run_xfer(rb, rack, rgl, model_frame(rb));
            repeat (10) tick();
        end

        // Device never clocks.
        d0 = n_done; e0 = n_err;
        start_req(8'hF4);
        for (int a = 0; a <= RETRIES; a++) begin
            measure_req(1);
            n = 0;
            while (!err && !clk_oe && n < TMO + 50) begin tick(); n++; end
            chk("timeout_len", n, TMO);
        end
        chk("timeout_err_pulse", err, 1);
        chk("timeout_oe_release", {clk_oe, dat_oe}, 0);
        tick();
        chk("timeout_ready", ready, 1);
        chk("timeout_oe_next", {clk_oe, dat_oe}, 0);
        chk("timeout_err_once", n_err - e0, 1);
        chk("timeout_no_done", n_done - d0, 0);
        repeat (10) tick();

        // Reset in the middle of a frame, then a clean retransmit.
        d0 = n_done; e0 = n_err;
        start_req(8'hF4);
        measure_req(1);
        dev_frame(4, 1'b1, 1'b0, smp);
        chk("midreset_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("midreset_oe", {clk_oe, dat_oe}, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_ready", ready, 1);
        chk("midreset_pulses", {done, err}, 0);
        rst = 1'b0;
        repeat (20) tick();
        chk("midreset_no_pulse_cnt", (n_done - d0) + (n_err - e0), 0);
        run_xfer(8'hF4, 1'b1, 1'b0, 11'b1_0_11110100_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
